// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM for the ALU datapath: decodes Opcode/Funct and drives
// every mux select and write enable, one state per clock.
module alu_seq_ctrl #(
    parameter logic [5:0] ADDM_OP = 6'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MDRWrite,
    output logic       ALUOutWrite,
    output logic       ABWrite,
    output logic       Exception
);

    localparam logic [4:0] S_RESET       = 5'd0;
    localparam logic [4:0] S_FETCH       = 5'd1;
    localparam logic [4:0] S_FETCH_WAIT  = 5'd2;
    localparam logic [4:0] S_DECODE      = 5'd3;
    localparam logic [4:0] S_R_EXEC      = 5'd4;
    localparam logic [4:0] S_R_WB        = 5'd5;
    localparam logic [4:0] S_I_EXEC      = 5'd6;
    localparam logic [4:0] S_I_WB        = 5'd7;
    localparam logic [4:0] S_BRANCH      = 5'd8;
    localparam logic [4:0] S_MEM_ADDR    = 5'd9;
    localparam logic [4:0] S_MEM_WR      = 5'd10;
    localparam logic [4:0] S_MEM_RD      = 5'd11;
    localparam logic [4:0] S_MEM_RD_WAIT = 5'd12;
    localparam logic [4:0] S_LW_WB       = 5'd13;
    localparam logic [4:0] S_ADDM_EXEC   = 5'd14;
    localparam logic [4:0] S_EXC         = 5'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    logic [4:0] state, next_state;

    logic is_r, is_imm, is_br, is_mem;
    logic op_addi, op_andi, op_beq, op_lw, op_sw, op_addm;
    logic fn_add, fn_sub, fn_and, fn_ok, fn_arith;

    assign is_r     = (Opcode == OP_RTYPE);
    assign op_addi  = (Opcode == OP_ADDI);
    assign op_andi  = (Opcode == OP_ANDI);
    assign op_beq   = (Opcode == OP_BEQ);
    assign op_lw    = (Opcode == OP_LW);
    assign op_sw    = (Opcode == OP_SW);
    assign op_addm  = (Opcode == ADDM_OP);
    assign is_imm   = op_addi || (Opcode == OP_ADDIU) || op_andi;
    assign is_br    = op_beq || (Opcode == OP_BNE);
    assign is_mem   = op_lw || op_sw || op_addm;
    assign fn_add   = (Funct == FN_ADD);
    assign fn_sub   = (Funct == FN_SUB);
    assign fn_and   = (Funct == FN_AND);
    assign fn_ok    = fn_add || fn_sub || fn_and;
    assign fn_arith = fn_add || fn_sub;

    always_ff @(posedge clk) begin
        if (reset) state <= S_RESET;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_RESET;
        case (state)
            S_RESET:      next_state = S_FETCH;
            S_FETCH:      next_state = S_FETCH_WAIT;
            S_FETCH_WAIT: next_state = S_DECODE;
            S_DECODE: begin
                if (is_r)        next_state = S_R_EXEC;
                else if (is_imm) next_state = S_I_EXEC;
                else if (is_br)  next_state = S_BRANCH;
                else if (is_mem) next_state = S_MEM_ADDR;
                else             next_state = S_EXC;
            end
            S_R_EXEC: begin
                if (!fn_ok || (fn_arith && Overflow)) next_state = S_EXC;
                else                                  next_state = S_R_WB;
            end
            S_R_WB:        next_state = S_FETCH;
            // ADDIU deliberately ignores Overflow
            S_I_EXEC:      next_state = (op_addi && Overflow) ? S_EXC : S_I_WB;
            S_I_WB:        next_state = S_FETCH;
            S_BRANCH:      next_state = S_FETCH;
            S_MEM_ADDR:    next_state = op_sw ? S_MEM_WR : S_MEM_RD;
            S_MEM_WR:      next_state = S_FETCH;
            S_MEM_RD:      next_state = S_MEM_RD_WAIT;
            S_MEM_RD_WAIT: next_state = op_lw ? S_LW_WB : S_ADDM_EXEC;
            S_LW_WB:       next_state = S_FETCH;
            S_ADDM_EXEC:   next_state = Overflow ? S_EXC : S_I_WB;
            S_EXC:         next_state = S_FETCH;
            default:       next_state = S_RESET;
        endcase
    end

    always_comb begin
        ALUSrcA     = 2'b00;
        ALUSrcB     = 3'b000;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        RegDst      = 2'b00;
        MemToReg    = 2'b00;
        PCWrite     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MDRWrite    = 1'b0;
        ALUOutWrite = 1'b0;
        ABWrite     = 1'b0;
        Exception   = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB = 3'b001;
                ALUOp   = 3'b001;
                PCWrite = 1'b1;
            end
            S_FETCH_WAIT: IRWrite = 1'b1;
            // ALUOut captures the branch target speculatively for every opcode
            S_DECODE: begin
                ABWrite     = 1'b1;
                ALUSrcB     = 3'b011;
                ALUOp       = 3'b001;
                ALUOutWrite = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA     = 2'b01;
                ALUOutWrite = 1'b1;
                if (fn_add)      ALUOp = 3'b001;
                else if (fn_sub) ALUOp = 3'b010;
                else if (fn_and) ALUOp = 3'b011;
            end
            S_R_WB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = op_andi ? 3'b100 : 3'b010;
                ALUOp       = op_andi ? 3'b011 : 3'b001;
                ALUOutWrite = 1'b1;
            end
            S_I_WB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 2'b01;
                ALUOp    = 3'b010;
                PCSource = 2'b01;
                PCWrite  = op_beq ? Zero : ~Zero;
            end
            S_MEM_ADDR: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 3'b010;
                ALUOp       = 3'b001;
                ALUOutWrite = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEM_RD: IorD = 1'b1;
            S_MEM_RD_WAIT: begin
                IorD     = 1'b1;
                MDRWrite = 1'b1;
            end
            S_LW_WB: begin
                MemToReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_ADDM_EXEC: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 3'b101;
                ALUOp       = 3'b001;
                ALUOutWrite = 1'b1;
            end
            S_EXC:   Exception = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: per-instruction expected output traces built from the
// instruction-level rules, compared every cycle, with random mid-instruction resets.
module tb_alu_seq_ctrl;

    localparam logic [5:0] ADDM = 6'h01;

    typedef struct packed {
        logic [1:0] sa;
        logic [2:0] sb;
        logic [2:0] op;
        logic [1:0] pcs;
        logic       iord;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       pcw, mw, irw, rw, mdrw, aow, abw, exc;
    } ov_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic       Zero, Overflow;
    logic [1:0] ALUSrcA, PCSource, RegDst, MemToReg;
    logic [2:0] ALUSrcB, ALUOp;
    logic       IorD, PCWrite, MemWrite, IRWrite, RegWrite, MDRWrite, ALUOutWrite, ABWrite, Exception;

    alu_seq_ctrl #(.ADDM_OP(ADDM)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Overflow(Overflow),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .IorD(IorD),
        .RegDst(RegDst), .MemToReg(MemToReg), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MDRWrite(MDRWrite), .ALUOutWrite(ALUOutWrite),
        .ABWrite(ABWrite), .Exception(Exception)
    );

    always #5 clk = ~clk;

    ov_t obs;
    assign obs = {ALUSrcA, ALUSrcB, ALUOp, PCSource, IorD, RegDst, MemToReg,
                  PCWrite, MemWrite, IRWrite, RegWrite, MDRWrite, ALUOutWrite, ABWrite, Exception};

    int n_chk = 0;
    int n_err = 0;
    ov_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, o, e);
        end
    endtask

    // Expected per-cycle outputs of one instruction, FETCH through its last state
    task automatic build(input logic [5:0] op, input logic [5:0] f, input logic z, input logic ov);
        ov_t s;
        logic exc;
        exp_q.delete();
        s = '0; s.sb = 3'd1; s.op = 3'd1; s.pcw = 1'b1; exp_q.push_back(s);
        s = '0; s.irw = 1'b1; exp_q.push_back(s);
        s = '0; s.abw = 1'b1; s.sb = 3'd3; s.op = 3'd1; s.aow = 1'b1; exp_q.push_back(s);
        exc = 1'b0;
        if (op == 6'h00) begin
            s = '0; s.sa = 2'd1; s.aow = 1'b1;
            case (f)
                6'h20: s.op = 3'd1;
                6'h22: s.op = 3'd2;
                6'h24: s.op = 3'd3;
                default: exc = 1'b1;
            endcase
            if ((f == 6'h20 || f == 6'h22) && ov) exc = 1'b1;
            exp_q.push_back(s);
            if (!exc) begin s = '0; s.rd = 2'd1; s.rw = 1'b1; exp_q.push_back(s); end
        end else if (op == 6'h08 || op == 6'h09 || op == 6'h0C) begin
            s = '0; s.sa = 2'd1; s.aow = 1'b1;
            s.sb = (op == 6'h0C) ? 3'd4 : 3'd2;
            s.op = (op == 6'h0C) ? 3'd3 : 3'd1;
            exp_q.push_back(s);
            exc = (op == 6'h08) && ov;
            if (!exc) begin s = '0; s.rw = 1'b1; exp_q.push_back(s); end
        end else if (op == 6'h04 || op == 6'h05) begin
            s = '0; s.sa = 2'd1; s.op = 3'd2; s.pcs = 2'd1;
            s.pcw = (op == 6'h04) ? z : !z;
            exp_q.push_back(s);
        end else if (op == 6'h23 || op == 6'h2B || op == ADDM) begin
            s = '0; s.sa = 2'd1; s.sb = 3'd2; s.op = 3'd1; s.aow = 1'b1; exp_q.push_back(s);
            if (op == 6'h2B) begin
                s = '0; s.iord = 1'b1; s.mw = 1'b1; exp_q.push_back(s);
            end else begin
                s = '0; s.iord = 1'b1; exp_q.push_back(s);
                s = '0; s.iord = 1'b1; s.mdrw = 1'b1; exp_q.push_back(s);
                if (op == 6'h23) begin
                    s = '0; s.m2r = 2'd1; s.rw = 1'b1; exp_q.push_back(s);
                end else begin
                    s = '0; s.sa = 2'd2; s.sb = 3'd5; s.op = 3'd1; s.aow = 1'b1; exp_q.push_back(s);
                    exc = ov;
                    if (!exc) begin s = '0; s.rw = 1'b1; exp_q.push_back(s); end
                end
            end
        end else begin
            exc = 1'b1;
        end
        if (exc) begin s = '0; s.exc = 1'b1; exp_q.push_back(s); end
    endtask

    // Called just after a rising edge with the DUT in FETCH; returns likewise.
    // abort_at >= 0 asserts reset after that cycle index has been checked.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input logic ov, input int abort_at);
        int n;
        Opcode = op; Funct = f; Zero = z; Overflow = ov;
        build(op, f, z, ov);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("op%02h_fn%02h_z%0d_v%0d_cyc%0d", op, f, z, ov, i + 1), 32'(obs), 32'(exp_q[i]));
            if (abort_at == i) begin
                reset = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                chk($sformatf("abort_op%02h_cyc%0d", op, i + 1), 32'(obs), 32'd0);
                reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] tbl [0:10];
        logic [5:0] o;
        tbl = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h04, 6'h05, 6'h23, 6'h2B, ADDM, 6'h3F};
        o = tbl[$urandom_range(0, 10)];
        if (o == 6'h3F) o = 6'($urandom_range(0, 63));
        return o;
    endfunction

    function automatic logic [5:0] rand_fn();
        logic [5:0] tbl [0:3];
        tbl = '{6'h20, 6'h22, 6'h24, 6'h00};
        return ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : tbl[$urandom_range(0, 3)];
    endfunction

    initial begin
        reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; Overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", 32'(obs), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LW aborted in MEM_RD (cycle 5) by reset
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 4);
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h20, 1'b0, 1'b1, -1);
        run_instr(6'h00, 6'h22, 1'b1, 1'b1, -1);
        run_instr(6'h00, 6'h24, 1'b0, 1'b1, -1);
        run_instr(6'h00, 6'h3F, 1'b0, 1'b0, -1);
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1);
        run_instr(6'h09, 6'h00, 1'b0, 1'b1, -1);
        run_instr(6'h0C, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h05, 6'h00, 1'b1, 1'b0, -1);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1);
        run_instr(ADDM,  6'h00, 1'b0, 1'b0, -1);
        run_instr(ADDM,  6'h00, 1'b0, 1'b1, -1);
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, -1);

        for (int k = 0; k < 150; k++) begin
            logic [5:0] op;
            int ab;
            op = rand_op();
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(op, rand_fn(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
